// File: rtl/register_pair_file_pkg.sv
// gb80_regfile_pkg: register and pair indices, inc/dec direction codes and
// the default flag-register mask of the GB80 register file.
package gb80_regfile_pkg;

  // Byte register indices. Pair p is {reg[2p] (high), reg[2p+1] (low)}.
  localparam int REG_B = 0;
  localparam int REG_C = 1;
  localparam int REG_D = 2;
  localparam int REG_E = 3;
  localparam int REG_H = 4;
  localparam int REG_L = 5;
  localparam int REG_A = 6;
  localparam int REG_F = 7;

  // Pair indices.
  localparam int PAIR_BC = 0;
  localparam int PAIR_DE = 1;
  localparam int PAIR_HL = 2;
  localparam int PAIR_AF = 3;

  // Values of i_incdec_dec.
  localparam logic INCDEC_INC = 1'b0;
  localparam logic INCDEC_DEC = 1'b1;

  // Only the upper nibble of F (Z, N, H, C) is storable.
  localparam logic [7:0] DEFAULT_FLAG_MASK = 8'hF0;

endpackage

// File: rtl/register_pair_file_if.sv
// register_pair_file_if: groups the write, inc/dec and read ports of the
// register file.
//   master : drives strobes/addresses/data, observes read data and conflict
//   slave  : the register file itself
interface register_pair_file_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
);

  logic                         i_wr_en;
  logic [ADDRESS_WIDTH-1:0]     i_wr_addr;
  logic [DATA_WIDTH-1:0]        i_wr_data;
  logic                         i_pair_wr_en;
  logic [ADDRESS_WIDTH-2:0]     i_pair_wr_addr;
  logic [2*DATA_WIDTH-1:0]      i_pair_wr_data;
  logic                         i_incdec_en;
  logic                         i_incdec_dec;
  logic [ADDRESS_WIDTH-2:0]     i_incdec_addr;
  logic                         i_rd_en;
  logic [ADDRESS_WIDTH-1:0]     i_rd_addr_a;
  logic [ADDRESS_WIDTH-1:0]     i_rd_addr_b;
  logic [ADDRESS_WIDTH-2:0]     i_pair_rd_addr;
  logic [DATA_WIDTH-1:0]        o_data_a;
  logic [DATA_WIDTH-1:0]        o_data_b;
  logic [2*DATA_WIDTH-1:0]      o_pair_data;
  logic                         o_wr_conflict;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data,
    output i_pair_wr_en, i_pair_wr_addr, i_pair_wr_data,
    output i_incdec_en, i_incdec_dec, i_incdec_addr,
    output i_rd_en, i_rd_addr_a, i_rd_addr_b, i_pair_rd_addr,
    input  o_data_a, o_data_b, o_pair_data, o_wr_conflict
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data,
    input  i_pair_wr_en, i_pair_wr_addr, i_pair_wr_data,
    input  i_incdec_en, i_incdec_dec, i_incdec_addr,
    input  i_rd_en, i_rd_addr_a, i_rd_addr_b, i_pair_rd_addr,
    output o_data_a, o_data_b, o_pair_data, o_wr_conflict
  );

endinterface

// File: rtl/register_pair_file_pair_incdec.sv
// pair_incdec: combinational +1 / -1 on a register pair, wrapping modulo
// 2**(2*DATA_WIDTH). The byte-to-byte carry stays internal.
//   i_value : current pair value
//   i_dec   : 0 = increment, 1 = decrement
//   o_value : modified pair value
module pair_incdec #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [2*DATA_WIDTH-1:0] i_value,
  input  logic                    i_dec,
  output logic [2*DATA_WIDTH-1:0] o_value
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW-1:0] ONE = PW'(1);

  // Result width equals operand width, so the wrap is implicit.
  assign o_value = i_dec ? (i_value - ONE) : (i_value + ONE);

endmodule

// File: rtl/register_pair_file.sv
// register_pair_file: GB80 register file of 2**ADDRESS_WIDTH byte registers
// grouped into 16-bit pairs.
//   i_clk   : clock, all state changes on the rising edge
//   i_reset : asynchronous active-high reset
//   bus     : byte write, pair write, pair inc/dec, two byte reads and one
//             pair read (registered, write-first), plus o_wr_conflict
// Per-register priority: pair write > inc/dec > byte write.
module register_pair_file
  import gb80_regfile_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDRESS_WIDTH = 3,
  parameter int                    FLAG_REG      = REG_F,
  parameter logic [DATA_WIDTH-1:0] FLAG_MASK     = DATA_WIDTH'(DEFAULT_FLAG_MASK)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  register_pair_file_if.slave    bus
);

  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
  localparam int PAIR_W   = ADDRESS_WIDTH - 1;
  localparam int DW       = DATA_WIDTH;

  logic [DW-1:0]   regs_q [NUM_REGS];
  logic [DW-1:0]   regs_d [NUM_REGS];
  logic [DW-1:0]   data_a_q, data_a_d;
  logic [DW-1:0]   data_b_q, data_b_d;
  logic [2*DW-1:0] pair_data_q, pair_data_d;
  logic            conflict_q, conflict_d;

  logic [2*DW-1:0] incdec_in;
  logic [2*DW-1:0] incdec_out;

  // Inc/dec always works from the stored value, never from same-cycle writes.
  assign incdec_in = {regs_q[{bus.i_incdec_addr, 1'b0}],
                      regs_q[{bus.i_incdec_addr, 1'b1}]};

  pair_incdec #(.DATA_WIDTH(DW)) u_pair_incdec (
    .i_value (incdec_in),
    .i_dec   (bus.i_incdec_dec),
    .o_value (incdec_out)
  );

  // Per-register next state, resolved by priority.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    regs_d     = regs_q;
    conflict_d = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (bus.i_pair_wr_en && bus.i_pair_wr_addr == PAIR_W'(r >> 1)) begin
        regs_d[r] = r[0] ? bus.i_pair_wr_data[DW-1:0]
                         : bus.i_pair_wr_data[2*DW-1:DW];
        if (bus.i_wr_en && bus.i_wr_addr == ADDRESS_WIDTH'(r)) conflict_d = 1'b1;
      end else if (bus.i_incdec_en && bus.i_incdec_addr == PAIR_W'(r >> 1)) begin
        regs_d[r] = r[0] ? incdec_out[DW-1:0] : incdec_out[2*DW-1:DW];
        if (bus.i_wr_en && bus.i_wr_addr == ADDRESS_WIDTH'(r)) conflict_d = 1'b1;
      end else if (bus.i_wr_en && bus.i_wr_addr == ADDRESS_WIDTH'(r)) begin
        regs_d[r] = bus.i_wr_data;
      end
      // Unwritable flag bits are forced to zero whatever the source.
      if (r == FLAG_REG) regs_d[r] = regs_d[r] & FLAG_MASK;
    end
  end

  // Write-first reads: select from the next-state vector, hold when disabled.
  always_comb begin
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    pair_data_d = pair_data_q;
    if (bus.i_rd_en) begin
      data_a_d    = regs_d[bus.i_rd_addr_a];
      data_b_d    = regs_d[bus.i_rd_addr_b];
      pair_data_d = {regs_d[{bus.i_pair_rd_addr, 1'b0}],
                     regs_d[{bus.i_pair_rd_addr, 1'b1}]};
    end
  end

  // NOTE: the storage array is reset like any other register because CPU
  // state must be known (all zero) right after reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      pair_data_q <= '0;
      conflict_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      regs_q      <= regs_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      pair_data_q <= pair_data_d;
      conflict_q  <= conflict_d;
    end
  end

  assign bus.o_data_a      = data_a_q;
  assign bus.o_data_b      = data_b_q;
  assign bus.o_pair_data   = pair_data_q;
  assign bus.o_wr_conflict = conflict_q;

endmodule

// File: tb/tb_register_pair_file.sv
// Self-checking bench for register_pair_file: directed scenarios followed by
// randomized traffic, all compared against a behavioural byte-array model.
module tb_register_pair_file;
  import gb80_regfile_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_pair_file_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  register_pair_file #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .FLAG_REG      (REG_F),
    .FLAG_MASK     (8'hF0)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: plain byte array plus expected registered outputs.
  logic [7:0]  m [8];
  logic [7:0]  exp_a, exp_b;
  logic [15:0] exp_p;
  logic        exp_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    exp_a = '0; exp_b = '0; exp_p = '0; exp_c = 1'b0;
  endtask

  // Apply one clock edge: lowest priority first so higher ones overwrite.
  task automatic model_edge();
    int          wr, pw, id;
    logic [15:0] pv;
    wr = int'(bus.i_wr_addr);
    pw = int'(bus.i_pair_wr_addr);
    id = int'(bus.i_incdec_addr);
    pv = {m[2*id], m[2*id+1]};
    if (bus.i_incdec_dec) pv = pv - 16'd1;
    else                  pv = pv + 16'd1;
    exp_c = bus.i_wr_en && ((bus.i_pair_wr_en && (wr / 2) == pw) ||
                            (bus.i_incdec_en  && (wr / 2) == id));
    if (bus.i_wr_en) m[wr] = bus.i_wr_data;
    if (bus.i_incdec_en) begin
      m[2*id] = pv[15:8]; m[2*id+1] = pv[7:0];
    end
    if (bus.i_pair_wr_en) begin
      m[2*pw] = bus.i_pair_wr_data[15:8]; m[2*pw+1] = bus.i_pair_wr_data[7:0];
    end
    m[REG_F] = m[REG_F] & 8'hF0;
    if (bus.i_rd_en) begin
      exp_a = m[bus.i_rd_addr_a];
      exp_b = m[bus.i_rd_addr_b];
      exp_p = {m[2*int'(bus.i_pair_rd_addr)], m[2*int'(bus.i_pair_rd_addr)+1]};
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".a"},    32'(bus.o_data_a),      32'(exp_a));
    check({tag, ".b"},    32'(bus.o_data_b),      32'(exp_b));
    check({tag, ".pair"}, 32'(bus.o_pair_data),   32'(exp_p));
    check({tag, ".conf"}, 32'(bus.o_wr_conflict), 32'(exp_c));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic idle();
    bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_pair_wr_en = 1'b0; bus.i_pair_wr_addr = '0; bus.i_pair_wr_data = '0;
    bus.i_incdec_en = 1'b0; bus.i_incdec_dec = INCDEC_INC; bus.i_incdec_addr = '0;
    bus.i_rd_en = 1'b0; bus.i_rd_addr_a = '0; bus.i_rd_addr_b = '0;
    bus.i_pair_rd_addr = '0;
  endtask

  task automatic pair_write(input int p, input logic [15:0] v);
    bus.i_pair_wr_en = 1'b1; bus.i_pair_wr_addr = (AW-1)'(p); bus.i_pair_wr_data = v;
  endtask

  task automatic byte_write(input int r, input logic [7:0] v);
    bus.i_wr_en = 1'b1; bus.i_wr_addr = AW'(r); bus.i_wr_data = v;
  endtask

  task automatic incdec(input int p, input logic dec);
    bus.i_incdec_en = 1'b1; bus.i_incdec_addr = (AW-1)'(p); bus.i_incdec_dec = dec;
  endtask

  task automatic read(input int ra, input int rb, input int p);
    bus.i_rd_en = 1'b1; bus.i_rd_addr_a = AW'(ra); bus.i_rd_addr_b = AW'(rb);
    bus.i_pair_rd_addr = (AW-1)'(p);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #2;
    check_outputs("reset");
    #10 rst = 1'b0;  // t=12, away from the edge at t=15

    // Byte/pair coherence.
    idle(); byte_write(REG_B, 8'hAB); step("wr_b");
    idle(); byte_write(REG_C, 8'hCD); step("wr_c");
    idle(); read(REG_B, REG_C, PAIR_BC); step("rd_bc");
    check("bc_pair", 32'(bus.o_pair_data), 32'h0000ABCD);
    idle(); pair_write(PAIR_HL, 16'h8001); read(REG_H, REG_L, PAIR_HL); step("wr_hl");
    check("h_byte", 32'(bus.o_data_a), 32'h80);
    check("l_byte", 32'(bus.o_data_b), 32'h01);

    // Wrap-around.
    idle(); pair_write(PAIR_HL, 16'hFFFF); step("hl_ffff");
    idle(); incdec(PAIR_HL, INCDEC_INC); read(REG_H, REG_L, PAIR_HL); step("hl_inc");
    check("hl_wrap", 32'(bus.o_pair_data), 32'h0000);
    idle(); pair_write(PAIR_DE, 16'h0000); step("de_0000");
    idle(); incdec(PAIR_DE, INCDEC_DEC); read(REG_D, REG_E, PAIR_DE); step("de_dec");
    check("de_wrap", 32'(bus.o_pair_data), 32'hFFFF);
    idle(); pair_write(PAIR_BC, 16'h00FF); step("bc_00ff");
    idle(); incdec(PAIR_BC, INCDEC_INC); read(REG_B, REG_C, PAIR_BC); step("bc_inc");
    check("bc_carry", 32'(bus.o_pair_data), 32'h0100);

    // Flag mask.
    idle(); byte_write(REG_F, 8'hFF); read(REG_F, REG_A, PAIR_AF); step("f_ff");
    check("f_mask", 32'(bus.o_data_a), 32'hF0);
    idle(); pair_write(PAIR_AF, 16'h12FF); read(REG_A, REG_F, PAIR_AF); step("af_12ff");
    check("af_mask", 32'(bus.o_pair_data), 32'h12F0);

    // Collisions.
    idle(); pair_write(PAIR_HL, 16'h5555); byte_write(REG_L, 8'h77);
    incdec(PAIR_HL, INCDEC_INC); read(REG_H, REG_L, PAIR_HL); step("collide");
    check("collide_hl", 32'(bus.o_pair_data), 32'h5555);
    check("collide_conf", 32'(bus.o_wr_conflict), 32'h1);
    idle(); step("collide_after");
    check("conf_one_cycle", 32'(bus.o_wr_conflict), 32'h0);
    idle(); byte_write(REG_B, 8'h11); incdec(PAIR_DE, INCDEC_INC);
    read(REG_B, REG_D, PAIR_DE); step("indep");
    check("indep_b", 32'(bus.o_data_a), 32'h11);
    check("indep_conf", 32'(bus.o_wr_conflict), 32'h0);

    // Forwarding and hold.
    idle(); byte_write(REG_E, 8'h3C); read(REG_E, REG_D, PAIR_DE); step("fwd_e");
    check("fwd_a", 32'(bus.o_data_a), 32'h3C);
    idle(); byte_write(REG_E, 8'h99); bus.i_rd_addr_a = AW'(REG_E); step("hold");
    check("hold_a", 32'(bus.o_data_a), 32'h3C);

    // Asynchronous reset mid-run.
    idle(); pair_write(PAIR_BC, 16'h1234); read(REG_B, REG_C, PAIR_BC); step("bc_1234");
    check("bc_loaded", 32'(bus.o_pair_data), 32'h1234);
    idle();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    #2 rst = 1'b0;
    idle(); read(REG_B, REG_C, PAIR_BC); step("bc_after_rst");
    check("bc_zero", 32'(bus.o_pair_data), 32'h0000);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bus.i_wr_en          = ($urandom_range(0, 99) < 60);
      bus.i_wr_addr        = AW'($urandom_range(0, 7));
      bus.i_wr_data        = 8'($urandom);
      bus.i_pair_wr_en     = ($urandom_range(0, 99) < 25);
      bus.i_pair_wr_addr   = (AW-1)'($urandom_range(0, 3));
      bus.i_pair_wr_data   = 16'($urandom);
      bus.i_incdec_en      = ($urandom_range(0, 99) < 35);
      bus.i_incdec_dec     = 1'($urandom_range(0, 1));
      bus.i_incdec_addr    = (AW-1)'($urandom_range(0, 3));
      bus.i_rd_en          = ($urandom_range(0, 99) < 75);
      bus.i_rd_addr_a      = AW'($urandom_range(0, 7));
      bus.i_rd_addr_b      = AW'($urandom_range(0, 7));
      bus.i_pair_rd_addr   = (AW-1)'($urandom_range(0, 3));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_pair_file.md
# register_pair_file

Parametrised CPU register file for the GB80 core: 2**ADDRESS_WIDTH byte registers grouped into 16-bit pairs, with one byte write port, one pair write port, a pair increment/decrement unit and two registered byte read ports plus one registered pair read port. It sits between the decoder/ALU datapath and the address unit, serving BC/DE/HL/AF operands, HL+/HL- addressing and 16-bit INC/DEC.

## Interface
- DATA_WIDTH, 8, width of one register
- ADDRESS_WIDTH, 3, register index width; register count 2**ADDRESS_WIDTH; pair index width ADDRESS_WIDTH-1
- FLAG_REG, 7, index of the flag register
- FLAG_MASK, 8'hF0, writable bits of FLAG_REG; masked bits always read 0
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_wr_en  in  1  byte write strobe
- i_wr_addr  in  ADDRESS_WIDTH  byte write index
- i_wr_data  in  DATA_WIDTH  byte write data
- i_pair_wr_en  in  1  pair write strobe
- i_pair_wr_addr  in  ADDRESS_WIDTH-1  pair write index
- i_pair_wr_data  in  2*DATA_WIDTH  pair write data, high byte first
- i_incdec_en  in  1  pair increment/decrement strobe
- i_incdec_dec  in  1  0 = +1, 1 = -1
- i_incdec_addr  in  ADDRESS_WIDTH-1  pair to modify
- i_rd_en  in  1  capture enable for all read ports
- i_rd_addr_a, i_rd_addr_b  in  ADDRESS_WIDTH  byte read indices
- i_pair_rd_addr  in  ADDRESS_WIDTH-1  pair read index
- o_data_a, o_data_b  out  DATA_WIDTH  registered byte read data
- o_pair_data  out  2*DATA_WIDTH  registered pair read data
- o_wr_conflict  out  1  registered pulse: byte write lost to a higher-priority source

## Operation
- Pair p = {reg[2p] (high), reg[2p+1] (low)}; default map B,C,D,E,H,L,A,F gives BC, DE, HL, AF.
- Inc/dec is modulo 2**(2*DATA_WIDTH): 16'hFFFF+1 = 16'h0000, 16'h0000-1 = 16'hFFFF; carry between bytes is internal, with no flag output.
- Writes to FLAG_REG from any source are ANDed with FLAG_MASK.
- Per-register priority in one cycle: pair write > inc/dec > byte write. Lower-priority sources for the same register are dropped. Independent registers all update in the same cycle.
- Pair write and inc/dec on the same pair: pair write wins, and inc/dec is dropped with no conflict flag.
- o_wr_conflict = 1 for one cycle after a cycle where i_wr_en targeted a register also written by a pair write or inc/dec; otherwise 0.
- Reads are write-first. When i_rd_en = 1, each read output captures the value the addressed register(s) will hold after this edge, including same-cycle writes and inc/dec results.
- When i_rd_en = 0, the read outputs hold.

## Timing
- Writes and inc/dec: value is visible in storage at the edge where the strobe is sampled.
- Reads: latency 1. Data appears on the cycle after i_rd_en is sampled and already reflects that cycle's writes (forwarded).
- Reset: all registers, o_data_a, o_data_b, o_pair_data and o_wr_conflict become 0 immediately and asynchronously. Strobes during reset are ignored.
- The first edge after reset deassertion performs normal operation.

## Structure
- Package gb80_regfile_pkg holds:
  - REG_B..REG_A/REG_F index localparams;
  - PAIR_BC/DE/HL/AF;
  - INCDEC_INC/INCDEC_DEC;
  - default FLAG_MASK.
- One sub-module, pair_incdec: combinational 2*DATA_WIDTH ±1 with wrap. It is instantiated once.
- Next-state is computed per register, and the forwarded read muxes select from that next-state vector.

## Test plan
- Reset mid-run: load BC=16'h1234, assert i_reset asynchronously -> all outputs 0 before the next edge; BC reads 0 after release.
- Byte/pair coherence: write B=8'hAB, C=8'hCD -> pair read BC = 16'hABCD. Pair write HL=16'h8001 -> byte reads H=8'h80, L=8'h01.
- Wrap: HL=16'hFFFF with inc -> 16'h0000. DE=16'h0000 with dec -> 16'hFFFF. BC=16'h00FF with inc -> 16'h0100.
- Flag mask: byte write F=8'hFF -> reads 8'hF0. Pair write AF=16'h12FF -> reads 16'h12F0.
- Collision: same cycle, pair write HL=16'h5555, byte write L=8'h77, inc HL -> HL=16'h5555 and o_wr_conflict=1 for exactly one cycle. Byte write B=8'h11 with inc DE in the same cycle -> both take effect and o_wr_conflict=0.
- Forwarding: i_rd_en with read A addressing E while byte-writing E=8'h3C -> o_data_a=8'h3C next cycle. With i_rd_en=0 -> o_data_a holds its previous value.
